apple_effect_unit: RTL and testbench
====================================

APPLE_EFFECT_UNIT -- requirements
Module: apple_effect_unit

Interface
REQ-001: Parameter EFFECT_TICKS, default 16: number of game ticks a lucky/unlucky effect lasts; legal range 1..255.
REQ-002: Parameter SCORE_W, default 8: score counter width in bits.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: state  input  2  GAME_STATE: RUN=00, WAIT=01, PAUSE=10, END_GAME=11.
REQ-006: apple_luck  input  2  APPLE_LUCK: NORMAL=00, LUCKY=01, UNLUCKY=10; 11 is treated as NORMAL.
REQ-007: apple_eaten  input  1  single-cycle pulse, snake head hit the apple.
REQ-008: tick  input  1  single-cycle pulse, one game movement step.
REQ-009: grow_pulse  output  1  registered one-cycle request to add one body segment.
REQ-010: shrink_pulse  output  1  registered one-cycle request to remove one body segment.
REQ-011: score  output  SCORE_W  current score.
REQ-012: speed_mode  output  2  00 = normal, 01 = slow (lucky), 10 = fast (unlucky).
REQ-013: ticks_left  output  8  remaining effect ticks; 0 when no effect is active.

Function
REQ-014: FSM states are IDLE, LUCKY_FX and UNLUCKY_FX; speed_mode SHALL be 00, 01 and 10 respectively, decoded directly from the state.
REQ-015: apple_eaten SHALL be acted on only when state == RUN; in all other states it is ignored.
REQ-016: On an accepted eat, outputs SHALL update on the next edge (latency 1), pulse for exactly one cycle, and use the apple_luck value sampled in the same cycle as apple_eaten.
REQ-017: NORMAL eat: grow_pulse = 1, score += 1; FSM state and ticks_left unchanged.
REQ-018: LUCKY eat: grow_pulse = 1, score += 2; FSM goes to LUCKY_FX; ticks_left reloads to EFFECT_TICKS.
REQ-019: UNLUCKY eat: shrink_pulse = 1, score -= 1; FSM goes to UNLUCKY_FX; ticks_left reloads to EFFECT_TICKS.
REQ-020: Score arithmetic SHALL saturate: it clamps at 2^SCORE_W-1 on increment and at 0 on decrement; it never wraps.
REQ-021: grow_pulse and shrink_pulse SHALL never be high in the same cycle.
REQ-022: In LUCKY_FX or UNLUCKY_FX with state == RUN, each tick SHALL decrement ticks_left by 1.
REQ-023: When ticks_left goes from 1 to 0, the FSM SHALL return to IDLE on the same edge.
REQ-024: A tick while state != RUN SHALL not change ticks_left; this freezes the effect during PAUSE.
REQ-025: If apple_eaten and tick coincide, the eat SHALL take priority: a lucky or unlucky reload wins and that tick is discarded; a normal eat lets the tick decrement apply.
REQ-026: A lucky or unlucky eat during an active effect SHALL replace it: the new effect type applies and ticks_left reloads, with no intermediate IDLE cycle.
REQ-027: state == END_GAME SHALL force IDLE and ticks_left = 0 on the next edge; score is held.
REQ-028: state == WAIT SHALL force IDLE, ticks_left = 0 and score = 0 on the next edge, as new-game setup.
REQ-029: With no accepted eat, grow_pulse and shrink_pulse SHALL be 0.

Reset
REQ-030: While rst is high at a clock edge, the block SHALL set the FSM to IDLE, score = 0, ticks_left = 0, speed_mode = 00, grow_pulse = 0 and shrink_pulse = 0.
REQ-031: rst SHALL take priority over every other input in the same cycle, including during an active effect or a coincident eat.
REQ-032: No output SHALL change asynchronously to clk.

Verification
REQ-033: Reset, then state = RUN, NORMAL eat -> next cycle grow_pulse = 1 for one cycle, score = 1, speed_mode = 00, ticks_left = 0.
REQ-034: RUN, LUCKY eat, then 16 ticks -> speed_mode = 01 with ticks_left = 16; after tick 15 ticks_left = 1; after tick 16 speed_mode = 00 and ticks_left = 0; score = 2.
REQ-035: UNLUCKY eat at score 0 -> shrink_pulse = 1, score stays 0, speed_mode = 10; then state = PAUSE with 5 ticks -> ticks_left stays 16; back to RUN with 1 tick -> ticks_left = 15.
REQ-036: In LUCKY_FX with ticks_left = 3, UNLUCKY eat coincident with a tick -> speed_mode = 10, ticks_left = 16, shrink_pulse = 1.
REQ-037: Score preset to 254 by 127 lucky-eat sequences, then one more LUCKY eat -> score = 255 and stays 255 on a further NORMAL eat.
REQ-038: Mid-effect with score = 10: assert rst for one cycle with apple_eaten = 1 -> all outputs are at reset values and no pulse is emitted; separately, state = WAIT -> score = 0 and FSM = IDLE.

Source files
------------

// File: rtl/apple_effect_if.sv
// apple_effect_if -- bundles the game-side signals of the apple effect unit.
//   master : game controller side (drives state, apple_luck, apple_eaten, tick;
//            observes the unit's outputs)
//   slave  : apple_effect_unit side
//   Signals:
//     state        [1:0]        game state: RUN=00, WAIT=01, PAUSE=10, END_GAME=11
//     apple_luck   [1:0]        NORMAL=00, LUCKY=01, UNLUCKY=10 (11 acts as NORMAL)
//     apple_eaten               one-cycle pulse, snake head hit the apple
//     tick                      one-cycle pulse, one game movement step
//     grow_pulse                one-cycle request to add a body segment
//     shrink_pulse              one-cycle request to remove a body segment
//     score        [SCORE_W-1:0] current score
//     speed_mode   [1:0]        00 normal, 01 slow (lucky), 10 fast (unlucky)
//     ticks_left   [7:0]        remaining effect ticks, 0 when no effect is active
interface apple_effect_if #(
  parameter int SCORE_W = 8
);
  logic [1:0]         state;
  logic [1:0]         apple_luck;
  logic               apple_eaten;
  logic               tick;
  logic               grow_pulse;
  logic               shrink_pulse;
  logic [SCORE_W-1:0] score;
  logic [1:0]         speed_mode;
  logic [7:0]         ticks_left;

  modport master (
    output state, apple_luck, apple_eaten, tick,
    input  grow_pulse, shrink_pulse, score, speed_mode, ticks_left
  );

  modport slave (
    input  state, apple_luck, apple_eaten, tick,
    output grow_pulse, shrink_pulse, score, speed_mode, ticks_left
  );
endinterface

// File: rtl/apple_effect_unit.sv
// apple_effect_unit -- scoring and timed lucky/unlucky speed effects for apples.
//   Parameters:
//     EFFECT_TICKS  ticks a lucky/unlucky effect lasts (1..255)
//     SCORE_W       score width; must match the interface instance's SCORE_W
//   Ports:
//     clk           rising-edge clock
//     rst           synchronous active-high reset
//     bus           apple_effect_if.slave (game inputs, registered outputs)
module apple_effect_unit #(
  parameter int EFFECT_TICKS = 16,
  parameter int SCORE_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  apple_effect_if.slave  bus
);

  typedef enum logic [1:0] {
    GS_RUN      = 2'b00,
    GS_WAIT     = 2'b01,
    GS_PAUSE    = 2'b10,
    GS_END_GAME = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    LUCK_NORMAL  = 2'b00,
    LUCK_LUCKY   = 2'b01,
    LUCK_UNLUCKY = 2'b10
  } apple_luck_t;

  // Encodings chosen so the effect state is the speed_mode value.
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LUCKY_FX   = 2'b01,
    UNLUCKY_FX = 2'b10
  } fx_state_t;

  localparam logic [7:0]         RELOAD    = 8'(EFFECT_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  fx_state_t          fx_q, fx_d;
  logic [7:0]         ticks_q, ticks_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               grow_q, grow_d;
  logic               shrink_q, shrink_d;

  // One extra bit catches the carry so increments clamp instead of wrapping.
  logic [SCORE_W:0]   score_inc1, score_inc2;

  assign score_inc1 = {1'b0, score_q} + (SCORE_W+1)'(1);
  assign score_inc2 = {1'b0, score_q} + (SCORE_W+1)'(2);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    fx_d     = fx_q;
    ticks_d  = ticks_q;
    score_d  = score_q;
    grow_d   = 1'b0;
    shrink_d = 1'b0;

    case (game_state_t'(bus.state))
      GS_RUN: begin
        // Tick countdown first; an eat below may overwrite it with a reload,
        // which is how a coincident lucky/unlucky eat discards the tick.
        if (bus.tick && fx_q != IDLE && ticks_q != 8'd0) begin
          ticks_d = ticks_q - 8'd1;
          if (ticks_q == 8'd1) fx_d = IDLE;
        end

        if (bus.apple_eaten) begin
          case (apple_luck_t'(bus.apple_luck))
            LUCK_LUCKY: begin
              grow_d  = 1'b1;
              score_d = score_inc2[SCORE_W] ? SCORE_MAX : score_inc2[SCORE_W-1:0];
              fx_d    = LUCKY_FX;
              ticks_d = RELOAD;
            end
            LUCK_UNLUCKY: begin
              shrink_d = 1'b1;
              score_d  = (score_q == '0) ? '0 : score_q - SCORE_W'(1);
              fx_d     = UNLUCKY_FX;
              ticks_d  = RELOAD;
            end
            default: begin
              grow_d  = 1'b1;
              score_d = score_inc1[SCORE_W] ? SCORE_MAX : score_inc1[SCORE_W-1:0];
            end
          endcase
        end
      end

      GS_WAIT: begin
        // New-game setup.
        fx_d    = IDLE;
        ticks_d = 8'd0;
        score_d = '0;
      end

      GS_END_GAME: begin
        // Final score stays visible.
        fx_d    = IDLE;
        ticks_d = 8'd0;
      end

      default: ;  // PAUSE: everything frozen
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      fx_q     <= IDLE;
      ticks_q  <= 8'd0;
      score_q  <= '0;
      grow_q   <= 1'b0;
      shrink_q <= 1'b0;
    end else begin
      fx_q     <= fx_d;
      ticks_q  <= ticks_d;
      score_q  <= score_d;
      grow_q   <= grow_d;
      shrink_q <= shrink_d;
    end
  end

  assign bus.grow_pulse   = grow_q;
  assign bus.shrink_pulse = shrink_q;
  assign bus.score        = score_q;
  assign bus.speed_mode   = fx_q;
  assign bus.ticks_left   = ticks_q;

endmodule

// File: tb/tb_apple_effect_unit.sv
// tb_apple_effect_unit -- directed, table-driven bench for apple_effect_unit.
//   A sequential vector table covers the basic eat/tick/state behaviour, then
//   hand-written sequences cover full effect expiry, pause freeze, effect
//   replacement, score saturation and reset/WAIT clearing.
module tb_apple_effect_unit;

  localparam int SCORE_W = 8;

  localparam logic [1:0] RUN = 2'b00, WAITS = 2'b01, PAUSE = 2'b10, ENDG = 2'b11;
  localparam logic [1:0] NRM = 2'b00, LCK = 2'b01, UNL = 2'b10, L11 = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests  = 0;
  int failed = 0;

  apple_effect_if #(.SCORE_W(SCORE_W)) bus ();

  apple_effect_unit #(.EFFECT_TICKS(16), .SCORE_W(SCORE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       r;
    logic [1:0] st;
    logic [1:0] luck;
    logic       eat;
    logic       tk;
    logic       grow;
    logic       shrink;
    int         score;
    logic [1:0] speed;
    int         ticks;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic [1:0] st, input logic [1:0] luck,
                      input logic eat, input logic tk);
    rst             = r;
    bus.state       = st;
    bus.apple_luck  = luck;
    bus.apple_eaten = eat;
    bus.tick        = tk;
    @(posedge clk);
    #1;
    check("grow_shrink_exclusive", int'(bus.grow_pulse & bus.shrink_pulse), 0);
  endtask

  task automatic expect_out(input string tag, input logic g, input logic s,
                            input int sc, input logic [1:0] sp, input int tl);
    check({tag, ".grow"},   int'(bus.grow_pulse),   int'(g));
    check({tag, ".shrink"}, int'(bus.shrink_pulse), int'(s));
    check({tag, ".score"},  int'(bus.score),        sc);
    check({tag, ".speed"},  int'(bus.speed_mode),   int'(sp));
    check({tag, ".ticks"},  int'(bus.ticks_left),   tl);
  endtask

  task automatic do_reset();
    step(1'b1, RUN, NRM, 1'b0, 1'b0);
  endtask

  initial begin
    bus.state = RUN; bus.apple_luck = NRM; bus.apple_eaten = 1'b0; bus.tick = 1'b0;

    //            r   st     luck eat tk  grow shr score speed ticks
    vecs[0]  = '{1'b1, RUN,   NRM, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 0};
    vecs[1]  = '{1'b0, RUN,   NRM, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2'b00, 0};
    vecs[2]  = '{1'b0, RUN,   NRM, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2'b00, 0};
    vecs[3]  = '{1'b0, RUN,   L11, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2'b00, 0};
    vecs[4]  = '{1'b0, PAUSE, LCK, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2'b00, 0};
    vecs[5]  = '{1'b0, RUN,   NRM, 1'b0, 1'b1, 1'b0, 1'b0, 2, 2'b00, 0};
    vecs[6]  = '{1'b0, RUN,   LCK, 1'b1, 1'b0, 1'b1, 1'b0, 4, 2'b01, 16};
    vecs[7]  = '{1'b0, RUN,   NRM, 1'b0, 1'b1, 1'b0, 1'b0, 4, 2'b01, 15};
    vecs[8]  = '{1'b0, RUN,   NRM, 1'b1, 1'b1, 1'b1, 1'b0, 5, 2'b01, 14};
    vecs[9]  = '{1'b0, ENDG,  LCK, 1'b1, 1'b1, 1'b0, 1'b0, 5, 2'b00, 0};
    vecs[10] = '{1'b0, RUN,   UNL, 1'b1, 1'b0, 1'b0, 1'b1, 4, 2'b10, 16};
    vecs[11] = '{1'b0, WAITS, NRM, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2'b00, 0};
    vecs[12] = '{1'b0, RUN,   UNL, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2'b10, 16};
    vecs[13] = '{1'b0, PAUSE, NRM, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2'b10, 16};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].r, vecs[i].st, vecs[i].luck, vecs[i].eat, vecs[i].tk);
      expect_out($sformatf("vec%0d", i), vecs[i].grow, vecs[i].shrink,
                 vecs[i].score, vecs[i].speed, vecs[i].ticks);
    end

    // Lucky effect runs its full 16 ticks and expires back to normal speed.
    do_reset();
    step(1'b0, RUN, LCK, 1'b1, 1'b0);
    expect_out("lucky_start", 1'b1, 1'b0, 2, 2'b01, 16);
    for (int t = 1; t <= 15; t++) begin
      step(1'b0, RUN, NRM, 1'b0, 1'b1);
      check($sformatf("lucky_tick%0d.ticks", t), int'(bus.ticks_left), 16 - t);
    end
    expect_out("lucky_tick15", 1'b0, 1'b0, 2, 2'b01, 1);
    step(1'b0, RUN, NRM, 1'b0, 1'b1);
    expect_out("lucky_expire", 1'b0, 1'b0, 2, 2'b00, 0);

    // Unlucky at score 0 clamps; PAUSE freezes the countdown.
    do_reset();
    step(1'b0, RUN, UNL, 1'b1, 1'b0);
    expect_out("unlucky_at0", 1'b0, 1'b1, 0, 2'b10, 16);
    for (int t = 0; t < 5; t++) step(1'b0, PAUSE, NRM, 1'b0, 1'b1);
    expect_out("pause_freeze", 1'b0, 1'b0, 0, 2'b10, 16);
    step(1'b0, RUN, NRM, 1'b0, 1'b1);
    expect_out("resume_tick", 1'b0, 1'b0, 0, 2'b10, 15);

    // Unlucky eat coincident with a tick replaces a running lucky effect.
    do_reset();
    step(1'b0, RUN, LCK, 1'b1, 1'b0);
    for (int t = 0; t < 13; t++) step(1'b0, RUN, NRM, 1'b0, 1'b1);
    expect_out("lucky_at3", 1'b0, 1'b0, 2, 2'b01, 3);
    step(1'b0, RUN, UNL, 1'b1, 1'b1);
    expect_out("replace_unlucky", 1'b0, 1'b1, 1, 2'b10, 16);

    // Score saturation at the top.
    do_reset();
    for (int n = 0; n < 127; n++) step(1'b0, RUN, LCK, 1'b1, 1'b0);
    expect_out("score_254", 1'b1, 1'b0, 254, 2'b01, 16);
    step(1'b0, RUN, LCK, 1'b1, 1'b0);
    expect_out("score_sat_lucky", 1'b1, 1'b0, 255, 2'b01, 16);
    step(1'b0, RUN, NRM, 1'b1, 1'b0);
    expect_out("score_sat_normal", 1'b1, 1'b0, 255, 2'b01, 16);
    step(1'b0, RUN, UNL, 1'b1, 1'b0);
    expect_out("score_dec_from_max", 1'b0, 1'b1, 254, 2'b10, 16);

    // Reset beats a coincident eat mid-effect.
    do_reset();
    for (int n = 0; n < 5; n++) step(1'b0, RUN, LCK, 1'b1, 1'b0);
    step(1'b0, RUN, NRM, 1'b0, 1'b1);
    expect_out("pre_rst", 1'b0, 1'b0, 10, 2'b01, 15);
    step(1'b1, RUN, LCK, 1'b1, 1'b1);
    expect_out("rst_priority", 1'b0, 1'b0, 0, 2'b00, 0);

    // WAIT clears score and effect.
    for (int n = 0; n < 5; n++) step(1'b0, RUN, LCK, 1'b1, 1'b0);
    step(1'b0, RUN, NRM, 1'b0, 1'b0);
    expect_out("pre_wait", 1'b0, 1'b0, 10, 2'b01, 16);
    step(1'b0, WAITS, NRM, 1'b0, 1'b0);
    expect_out("wait_clear", 1'b0, 1'b0, 0, 2'b00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
